fb_rect_fill: RTL and testbench
===============================

Name: fb_rect_fill

Overview:
- Upstream writer for the 24-bit framebuffer RAM that the VGA scan-out stage reads.
- Accepts rectangle-fill commands (origin, size, colour) over a valid/ready handshake.
- Generates one framebuffer write per granted cycle, in raster order (row by row, left to right).
- An external arbiter grants RAM write slots (e.g. during blanking), so fills never collide with scan-out reads.

Parameters:
- FB_W, 200, visible pixels per line.
- FB_H, 600, visible lines per frame.
- ADR_W, 17, framebuffer address width.
- PIX_W, 24, pixel width, packed R[23:16] G[15:8] B[7:0].

Ports:
- CLOCK_50 in 1: single system clock; all logic on its rising edge.
- reset in 1: synchronous, active-high.
- cmd_valid in 1: command present.
- cmd_ready out 1: engine can accept a command.
- cmd_x in 8: origin column.
- cmd_y in 10: origin line.
- cmd_w in 9: width in pixels, 0..FB_W.
- cmd_h in 10: height in lines, 0..FB_H.
- cmd_color in PIX_W: fill colour.
- fb_grant in 1: RAM write slot available this cycle.
- fb_we out 1: write strobe, active-high.
- fb_adr out ADR_W: write address.
- fb_d out PIX_W: write data.
- busy out 1: fill in progress.
- done out 1: one-cycle pulse when a command completes.
- cmd_err out 1: one-cycle pulse when a command is rejected.

Behaviour:
- Interface: one clock (CLOCK_50); reset is synchronous and active-high.
- Reset values: state IDLE, cmd_ready=1, fb_we=0, fb_adr=0, fb_d=0, busy=0, done=0, cmd_err=0.
- States are IDLE and FILL.
- IDLE:
  - cmd_ready=1.
  - Accept occurs when cmd_valid && cmd_ready. On accept, latch x0, w, colour and the line count.
  - row_base = cmd_y*FB_W. Compute it once at accept; no multiplier in the fill loop.
  - On accept, set x_cur=0 and go to FILL.
- FILL:
  - cmd_ready=0, busy=1.
  - fb_we = fb_grant.
  - fb_adr = row_base + x0 + x_cur.
  - fb_d = latched colour.
  - These three outputs are combinational from registered state.
- Grant handling:
  - fb_grant=1: advance x_cur.
  - At x_cur==w-1: x_cur=0, row_base += FB_W, decrement the line count.
  - fb_grant=0: hold all state; no write is issued.
- Completion:
  - After the final pixel is written, return to IDLE.
  - done pulses in the first IDLE cycle, which is also the first cycle cmd_ready=1 again.
- Latency:
  - The first write can occur in the cycle after accept.
  - With continuous grant, a w×h fill takes exactly w*h write cycles.
  - The next command can be accepted in the cycle done is high.
- Zero-size commands (w==0 or h==0):
  - Accepted and go directly back to IDLE with no writes.
  - done pulses the following cycle; busy stays 0.
- Bounds: a command is out-of-range if x0+w>FB_W or y+h>FB_H. Handling depends on FILL_CLIP_EN (see Optional Feature).
- Address arithmetic:
  - Unsigned, ADR_W bits.
  - Maximum address is 199+599*200=119999, so it never overflows.
- Reset mid-fill: the fill is aborted. No further writes, no done pulse, and the engine is in IDLE next cycle.
- cmd_valid while busy: ignored, since cmd_ready=0. The source must hold cmd_valid and command fields until accepted.

Optional Feature:
- Macro: FB_RECT_FILL_CLIP_EN.
- Defined:
  - Out-of-range rectangles are clipped at accept: w_eff=min(w, FB_W-x0) and h_eff=min(h, FB_H-y).
  - Origins with x0>=FB_W or y>=FB_H give an empty fill, which then follows the zero-size behaviour.
  - cmd_err is never asserted.
- Undefined:
  - Out-of-range commands are accepted and dropped with no writes.
  - cmd_err pulses the cycle after accept; done is not pulsed.
  - The engine stays in IDLE.

Decomposition:
- Package fb_pkg holds:
  - Constants FB_W, FB_H, ADR_W, PIX_W.
  - Typedef pixel_t (PIX_W-bit logic), shared with the VGA scan-out stage.
  - Typedef fb_adr_t.
  - Enum fill_state_t {IDLE, FILL}.
- One natural sub-module, fb_rect_walker: the x_cur/line counters and row_base accumulator, exposing adr, last and an advance input.
- The FSM and handshake stay in fb_rect_fill.

Test Plan:
- Basic fill: cmd (x=10, y=5, w=3, h=2, colour 0xFF0000) with fb_grant=1.
  - Expect 6 consecutive writes to addresses 1010, 1011, 1012, 1210, 1211, 1212, all with fb_d=0xFF0000.
  - Expect done one cycle after the last write.
- Grant stall: same command with fb_grant low on alternate cycles.
  - Same 6 addresses in order, no write while grant=0, 12 cycles total, address held during stalls.
- Zero-size: cmd w=0, h=4 → no fb_we, busy stays 0, done the cycle after accept, cmd_ready=1 throughout the following cycle.
- Bounds: cmd (x=198, y=0, w=5, h=1).
  - With FB_RECT_FILL_CLIP_EN: writes to 198 and 199 only, then done.
  - Without: cmd_err pulse, zero writes.
- Reset mid-fill: cmd (0, 0, 200, 600), reset asserted after 50 writes → fb_we=0 from the next cycle, no done, cmd_ready=1.
- Back-to-back:
  - Two 1×1 commands at (0,0) and (199,599), presented with cmd_valid held.
  - Second is accepted in the done cycle of the first; writes to 0 then 119999.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared framebuffer definitions for the rectangle-fill engine and the VGA
// scan-out stage: geometry constants, pixel/address types, command field
// types and the fill FSM state encoding.
// -----------------------------------------------------------------------------
package fb_pkg;

  localparam int FB_W  = 200;  // visible pixels per line
  localparam int FB_H  = 600;  // visible lines per frame
  localparam int ADR_W = 17;   // framebuffer address width
  localparam int PIX_W = 24;   // R[23:16] G[15:8] B[7:0]

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [ADR_W-1:0] fb_adr_t;

  // Command field widths.
  typedef logic [7:0] x_t;
  typedef logic [9:0] y_t;
  typedef logic [8:0] w_t;
  typedef logic [9:0] h_t;

  typedef enum logic {IDLE, FILL} fill_state_t;

  // Address of the first pixel of line y. Constant multiplier, used only
  // at command accept, so the fill loop itself is adder-only.
  function automatic fb_adr_t row_base_of(input y_t y);
    return fb_adr_t'(y) * fb_adr_t'(FB_W);
  endfunction

endpackage

// File: rtl/fb_rect_fill_if.sv
// -----------------------------------------------------------------------------
// fb_rect_fill_if
// Bundles the command handshake and the framebuffer write port of the
// rectangle-fill engine.
//   cmd_valid/cmd_ready   : command handshake
//   cmd_x/y/w/h/color     : command fields (held by source until accepted)
//   fb_grant              : arbiter grants a RAM write slot this cycle
//   fb_we/fb_adr/fb_d     : framebuffer write port
// Modports: slave = fill engine, master = command source + RAM/arbiter side.
// -----------------------------------------------------------------------------
interface fb_rect_fill_if;
  import fb_pkg::*;

  logic    cmd_valid;
  logic    cmd_ready;
  x_t      cmd_x;
  y_t      cmd_y;
  w_t      cmd_w;
  h_t      cmd_h;
  pixel_t  cmd_color;
  logic    fb_grant;
  logic    fb_we;
  fb_adr_t fb_adr;
  pixel_t  fb_d;

  modport slave (
    input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_grant,
    output cmd_ready, fb_we, fb_adr, fb_d
  );

  modport master (
    output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color, fb_grant,
    input  cmd_ready, fb_we, fb_adr, fb_d
  );

endinterface

// File: rtl/fb_rect_walker.sv
// -----------------------------------------------------------------------------
// fb_rect_walker
// Raster-order address generator for one rectangle: column counter, line
// counter and a row-base accumulator that steps by FB_W per line.
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_load         : capture a new rectangle (x0, w, h, row base of line y)
//   i_advance      : one pixel has been written; step to the next
//   o_adr          : address of the current pixel
//   o_last         : current pixel is the final one of the rectangle
// Loaded w and h must be non-zero.
// -----------------------------------------------------------------------------
module fb_rect_walker
  import fb_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst,
  input  logic    i_load,
  input  x_t      i_x0,
  input  w_t      i_w,
  input  h_t      i_h,
  input  fb_adr_t i_row_base,
  input  logic    i_advance,
  output fb_adr_t o_adr,
  output logic    o_last
);

  x_t      r_x0;
  w_t      r_w;
  w_t      r_x_cur;
  h_t      r_lines;     // lines remaining, including the current one
  fb_adr_t r_row_base;

  logic w_row_end;

  assign w_row_end = (r_x_cur == r_w - w_t'(1));
  assign o_last    = w_row_end && (r_lines == h_t'(1));
  assign o_adr     = r_row_base + fb_adr_t'(r_x0) + fb_adr_t'(r_x_cur);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x0       <= '0;
      r_w        <= '0;
      r_x_cur    <= '0;
      r_lines    <= '0;
      r_row_base <= '0;
    end else if (i_load) begin
      r_x0       <= i_x0;
      r_w        <= i_w;
      r_x_cur    <= '0;
      r_lines    <= i_h;
      r_row_base <= i_row_base;
    end else if (i_advance) begin
      if (w_row_end) begin
        r_x_cur    <= '0;
        r_row_base <= r_row_base + fb_adr_t'(FB_W);
        r_lines    <= r_lines - h_t'(1);
      end else begin
        r_x_cur    <= r_x_cur + w_t'(1);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// -----------------------------------------------------------------------------
// fb_rect_fill
// Rectangle-fill engine: accepts fill commands and emits one framebuffer
// write per granted cycle, in raster order.
//   CLOCK_50  : system clock (rising edge)
//   reset     : synchronous, active-high; aborts any fill in progress
//   bus       : fb_rect_fill_if.slave (command handshake + RAM write port)
//   busy      : fill in progress
//   done      : one-cycle pulse in the first IDLE cycle after a command ends
//   cmd_err   : one-cycle pulse after an out-of-range command is dropped
// Build option: define FB_RECT_FILL_CLIP_EN to clip out-of-range rectangles
// to the screen instead of rejecting them with cmd_err.
// -----------------------------------------------------------------------------
module fb_rect_fill
  import fb_pkg::*;
(
  input  logic           CLOCK_50,
  input  logic           reset,
  fb_rect_fill_if.slave  bus,
  output logic           busy,
  output logic           done,
  output logic           cmd_err
);

  // 11-bit extents hold x0+w (<= 766) and y+h (<= 2046) without wrap.
  localparam logic [10:0] FB_W_EXT = 11'(FB_W);
  localparam logic [10:0] FB_H_EXT = 11'(FB_H);

  fill_state_t r_state;
  pixel_t      r_color;
  logic        r_done;
  logic        r_err;

  logic        w_fill;
  logic        w_accept;
  logic [10:0] w_x_end;
  logic [10:0] w_y_end;
  w_t          w_w_eff;
  h_t          w_h_eff;
  logic        w_zero;
  logic        w_oob;
  logic        w_load;
  logic        w_advance;
  logic        w_last;
  fb_adr_t     w_adr;

  assign w_fill   = (r_state == FILL);
  assign w_accept = bus.cmd_valid && (r_state == IDLE);
  assign w_x_end  = {3'b000, bus.cmd_x} + {2'b00, bus.cmd_w};
  assign w_y_end  = {1'b0, bus.cmd_y} + {1'b0, bus.cmd_h};

  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_w_eff = bus.cmd_w;
    w_h_eff = bus.cmd_h;
    w_oob   = 1'b0;
`ifdef FB_RECT_FILL_CLIP_EN
    // An origin off-screen yields an empty rectangle (zero-size path).
    if ({3'b000, bus.cmd_x} >= FB_W_EXT)
      w_w_eff = '0;
    else if (w_x_end > FB_W_EXT)
      w_w_eff = w_t'(FB_W_EXT - {3'b000, bus.cmd_x});
    if ({1'b0, bus.cmd_y} >= FB_H_EXT)
      w_h_eff = '0;
    else if (w_y_end > FB_H_EXT)
      w_h_eff = h_t'(FB_H_EXT - {1'b0, bus.cmd_y});
`else
    w_oob = (w_x_end > FB_W_EXT) || (w_y_end > FB_H_EXT);
`endif
  end

  // Zero-size is checked before bounds: an empty command completes with
  // done even if its origin lies off-screen.
  assign w_zero    = (w_w_eff == '0) || (w_h_eff == '0);
  assign w_load    = w_accept && !w_zero && !w_oob;
  assign w_advance = w_fill && bus.fb_grant;

  fb_rect_walker u_walker (
    .i_clk      (CLOCK_50),
    .i_rst      (reset),
    .i_load     (w_load),
    .i_x0       (bus.cmd_x),
    .i_w        (w_w_eff),
    .i_h        (w_h_eff),
    .i_row_base (row_base_of(bus.cmd_y)),
    .i_advance  (w_advance),
    .o_adr      (w_adr),
    .o_last     (w_last)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= IDLE;
      r_color <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_zero) begin
              r_done <= 1'b1;
            end else if (w_oob) begin
              r_err <= 1'b1;
            end else begin
              r_color <= bus.cmd_color;
              r_state <= FILL;
            end
          end
        end
        FILL: begin
          if (bus.fb_grant && w_last) begin
            r_state <= IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write port is combinational from registered state; forced to zero
  // outside FILL so idle outputs match the reset values.
  assign bus.cmd_ready = (r_state == IDLE);
  assign bus.fb_we     = w_advance;
  assign bus.fb_adr    = w_fill ? w_adr   : '0;
  assign bus.fb_d      = w_fill ? r_color : '0;
  assign busy          = w_fill;
  assign done          = r_done;
  assign cmd_err       = r_err;

endmodule

// File: tb/tb_fb_rect_fill.sv
// -----------------------------------------------------------------------------
// tb_fb_rect_fill
// Directed self-checking bench for fb_rect_fill. Inputs are driven and
// outputs sampled 1 time unit after the rising edge. Honours
// FB_RECT_FILL_CLIP_EN for the out-of-range case.
// -----------------------------------------------------------------------------
module tb_fb_rect_fill;
  import fb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  logic done;
  logic cmd_err;

  int total = 0;
  int bad   = 0;

  fb_rect_fill_if bus ();

  fb_rect_fill dut (
    .CLOCK_50 (clk),
    .reset    (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .done     (done),
    .cmd_err  (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] x, input logic [9:0] y, input logic [8:0] w,
                      input logic [9:0] h, input logic [23:0] c);
    bus.cmd_valid = 1'b1;
    bus.cmd_x     = x;
    bus.cmd_y     = y;
    bus.cmd_w     = w;
    bus.cmd_h     = h;
    bus.cmd_color = c;
  endtask

  // Hand-computed: 5*200 + 10 = 1010, next line +200.
  int unsigned basic_adr [6] = '{1010, 1011, 1012, 1210, 1211, 1212};

  initial begin
    int k;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_x     = '0;
    bus.cmd_y     = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    bus.fb_grant  = 1'b0;
    repeat (3) tick();

    // Reset state
    check("rst_ready", bus.cmd_ready, 1);
    check("rst_we",    bus.fb_we,     0);
    check("rst_adr",   bus.fb_adr,    0);
    check("rst_d",     bus.fb_d,      0);
    check("rst_busy",  busy,          0);
    check("rst_done",  done,          0);
    check("rst_err",   cmd_err,       0);
    rst = 1'b0;
    tick();

    // Basic fill, continuous grant
    send(8'd10, 10'd5, 9'd3, 10'd2, 24'hFF0000);
    bus.fb_grant = 1'b1;
    #1;
    check("basic_ready_idle", bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      check("basic_we",   bus.fb_we,  1);
      check("basic_adr",  bus.fb_adr, basic_adr[i]);
      check("basic_d",    bus.fb_d,   32'hFF0000);
      check("basic_busy", busy,       1);
      check("basic_nodone", done,     0);
      tick();
    end
    check("basic_done",     done,          1);
    check("basic_we_off",   bus.fb_we,     0);
    check("basic_ready",    bus.cmd_ready, 1);
    tick();
    check("basic_done_end", done,          0);

    // Grant stall: grant low on even cycles, 12 cycles for 6 writes
    send(8'd10, 10'd5, 9'd3, 10'd2, 24'hFF0000);
    tick();
    bus.cmd_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 12; c++) begin
      bus.fb_grant = (c % 2 == 1);
      #1;
      check("stall_we",   bus.fb_we,  (c % 2 == 1) ? 1 : 0);
      check("stall_adr",  bus.fb_adr, basic_adr[k]);
      check("stall_busy", busy,       1);
      if (c % 2 == 1) k++;
      tick();
    end
    check("stall_done", done, 1);
    check("stall_busy_off", busy, 0);
    tick();

    // Zero-size: accepted, no writes, done next cycle
    bus.fb_grant = 1'b1;
    send(8'd0, 10'd0, 9'd0, 10'd4, 24'h123456);
    tick();
    bus.cmd_valid = 1'b0;
    check("zero_done",  done,          1);
    check("zero_busy",  busy,          0);
    check("zero_we",    bus.fb_we,     0);
    check("zero_ready", bus.cmd_ready, 1);
    tick();
    check("zero_done_end", done,       0);
    check("zero_ready2", bus.cmd_ready, 1);
    check("zero_we2",   bus.fb_we,     0);

    // Out-of-range rectangle at the right edge
    send(8'd198, 10'd0, 9'd5, 10'd1, 24'h00FF00);
    tick();
    bus.cmd_valid = 1'b0;
`ifdef FB_RECT_FILL_CLIP_EN
    check("clip_we0",  bus.fb_we,  1);
    check("clip_adr0", bus.fb_adr, 198);
    check("clip_d0",   bus.fb_d,   32'h00FF00);
    tick();
    check("clip_we1",  bus.fb_we,  1);
    check("clip_adr1", bus.fb_adr, 199);
    tick();
    check("clip_done", done,       1);
    check("clip_we_off", bus.fb_we, 0);
    check("clip_err",  cmd_err,    0);
`else
    check("oob_err",   cmd_err,    1);
    check("oob_we",    bus.fb_we,  0);
    check("oob_busy",  busy,       0);
    check("oob_done",  done,       0);
    tick();
    check("oob_err_end", cmd_err,  0);
    check("oob_done2", done,       0);
    check("oob_we2",   bus.fb_we,  0);
`endif
    tick();

    // Reset mid-fill after 50 writes
    send(8'd0, 10'd0, 9'd200, 10'd600, 24'h0000FF);
    tick();
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (i == 0 || i == 49) check("mid_adr", bus.fb_adr, i);
      tick();
    end
    check("mid_adr50", bus.fb_adr, 50);
    rst = 1'b1;
    tick();
    check("mid_we",    bus.fb_we,     0);
    check("mid_done",  done,          0);
    check("mid_ready", bus.cmd_ready, 1);
    check("mid_busy",  busy,          0);
    rst = 1'b0;
    tick();
    check("mid_done2", done,          0);
    check("mid_we2",   bus.fb_we,     0);

    // Back-to-back 1x1 commands, cmd_valid held
    send(8'd0, 10'd0, 9'd1, 10'd1, 24'hAAAAAA);
    tick();
    check("b2b_we0",    bus.fb_we,     1);
    check("b2b_adr0",   bus.fb_adr,    0);
    check("b2b_d0",     bus.fb_d,      32'hAAAAAA);
    check("b2b_nready", bus.cmd_ready, 0);
    send(8'd199, 10'd599, 9'd1, 10'd1, 24'h555555);
    tick();
    check("b2b_done0",  done,          1);
    check("b2b_ready",  bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    check("b2b_we1",    bus.fb_we,     1);
    check("b2b_adr1",   bus.fb_adr,    119999);
    check("b2b_d1",     bus.fb_d,      32'h555555);
    check("b2b_nodone", done,          0);
    tick();
    check("b2b_done1",  done,          1);
    check("b2b_we_off", bus.fb_we,     0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
